// File: rtl/mem_ctrl_pkg.sv
// Shared constants for the two-port memory arbiter: FSM encoding, default
// bus widths and requester port indices.
package mem_ctrl_pkg;

  localparam int MEM_ADDR_W = 5;
  localparam int MEM_DATA_W = 8;

  // Sequencer state encoding.
  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_WRITE   = 2'd1;
  localparam logic [1:0] ST_READ    = 2'd2;
  localparam logic [1:0] ST_CAPTURE = 2'd3;

  // Requester port indices.
  localparam int PORT_CPU = 0;
  localparam int PORT_LDR = 1;

  // One-hot vector for a port index (bit 0 = CPU, bit 1 = loader).
  function automatic logic [1:0] port_onehot(input logic idx);
    return idx ? 2'b10 : 2'b01;
  endfunction

endpackage

// File: rtl/mem_arbiter_if.sv
// Request/grant/acknowledge bundle between one requester and the arbiter.
interface mem_arbiter_if
  import mem_ctrl_pkg::*;
#(
  parameter int ADDR_W = MEM_ADDR_W,
  parameter int DATA_W = MEM_DATA_W
);

  logic              req;
  logic              we;
  logic [ADDR_W-1:0] addr;
  logic [DATA_W-1:0] wdata;
  logic              gnt;
  logic              ack;

  modport master (output req, we, addr, wdata, input gnt, ack);
  modport slave  (input req, we, addr, wdata, output gnt, ack);

endinterface

// File: rtl/rr_arbiter2.sv
// Two-request round-robin arbiter. The pointer remembers the last granted
// port and moves only when the caller pulses advance on an accepted grant.
module rr_arbiter2
  import mem_ctrl_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] req,
  input  logic       advance,
  output logic [1:0] gnt
);

  logic last;  // index of the most recently granted port

  // One-hot winner: a lone request wins, a tie goes to the port not served last.
  always_comb begin
    // NOTE: default first so every path assigns gnt and no latch is inferred.
    gnt = 2'b00;
    case (req)
      2'b01:   gnt = 2'b01;
      2'b10:   gnt = 2'b10;
      2'b11:   gnt = (last == 1'(PORT_LDR)) ? 2'b01 : 2'b10;
      default: gnt = 2'b00;
    endcase
  end

  // Pointer update; reset leaves it on the loader so the CPU wins the first tie.
  always_ff @(posedge clk) begin
    // NOTE: state registers use non-blocking assignments so every flop samples
    // pre-edge values regardless of statement order.
    if (!rst_n) begin
      last <= 1'(PORT_LDR);
    end else if (advance && (gnt != 2'b00)) begin
      last <= gnt[1];
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// Two-port arbiter and sequencer for a 32 x 8 single-port memory with a
// shared bidirectional data bus. Grants one transaction at a time, sequences
// the rd/wr strobes and owns the controller side of the tri-state bus.
module mem_arbiter
  import mem_ctrl_pkg::*;
#(
  parameter int ADDR_W = MEM_ADDR_W,
  parameter int DATA_W = MEM_DATA_W
)(
  input  logic              clk,
  input  logic              rst_n,
  mem_arbiter_if.slave      p0,
  mem_arbiter_if.slave      p1,
  output logic [DATA_W-1:0] rdata,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_rd,
  output logic              mem_wr,
  inout  wire  [DATA_W-1:0] mem_data
);

  logic [1:0]        state;
  logic              owner;     // port that owns the current transaction
  logic              we_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q;
  logic [1:0]        gnt_q;
  logic [1:0]        ack_q;
  logic [DATA_W-1:0] rdata_q;

  logic [1:0]        arb_gnt;
  logic              start;
  logic              sel_we;
  logic [ADDR_W-1:0] sel_addr;
  logic [DATA_W-1:0] sel_wdata;
  logic              data_oe;

  // A transaction starts only from IDLE; this also advances the RR pointer.
  assign start = (state == ST_IDLE) && (arb_gnt != 2'b00);

  rr_arbiter2 u_arb (
    .clk     (clk),
    .rst_n   (rst_n),
    .req     ({p1.req, p0.req}),
    .advance (start),
    .gnt     (arb_gnt)
  );

  // Select the winning port's request fields for latching.
  always_comb begin
    sel_we    = p0.we;
    sel_addr  = p0.addr;
    sel_wdata = p0.wdata;
    if (arb_gnt[1]) begin
      sel_we    = p1.we;
      sel_addr  = p1.addr;
      sel_wdata = p1.wdata;
    end
  end

  // Sequencer FSM with latched request, grant/ack pulses and read capture.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state   <= ST_IDLE;
      owner   <= 1'b0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      gnt_q   <= 2'b00;
      ack_q   <= 2'b00;
      rdata_q <= '0;
    end else begin
      gnt_q <= 2'b00;
      ack_q <= 2'b00;
      case (state)
        ST_IDLE: begin
          if (start) begin
            owner   <= arb_gnt[1];
            we_q    <= sel_we;
            addr_q  <= sel_addr;
            wdata_q <= sel_wdata;
            gnt_q   <= arb_gnt;
            state   <= sel_we ? ST_WRITE : ST_READ;
          end
        end
        ST_WRITE: begin
          ack_q <= port_onehot(owner);
          state <= ST_IDLE;
        end
        ST_READ: begin
          state <= ST_CAPTURE;
        end
        ST_CAPTURE: begin
          rdata_q <= mem_data;
          ack_q   <= port_onehot(owner);
          state   <= ST_IDLE;
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

  // Moore strobes decoded from the state register only; the bus is driven
  // solely in WRITE, so CAPTURE -> IDLE -> WRITE guarantees turnaround.
  assign mem_rd   = (state == ST_READ) || (state == ST_CAPTURE);
  assign mem_wr   = (state == ST_WRITE);
  assign data_oe  = (state == ST_WRITE) && we_q;
  assign mem_data = data_oe ? wdata_q : 'z;
  assign mem_addr = addr_q;
  assign rdata    = rdata_q;

  assign p0.gnt = gnt_q[PORT_CPU];
  assign p1.gnt = gnt_q[PORT_LDR];
  assign p0.ack = ack_q[PORT_CPU];
  assign p1.ack = ack_q[PORT_LDR];

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter with a behavioural 32 x 8 memory on the
// shared tri-state bus and a per-cycle bus-protocol monitor.
module tb_mem_arbiter;
  import mem_ctrl_pkg::*;

  logic       clk;
  logic       rst_n;
  logic [7:0] rdata;
  logic [4:0] mem_addr;
  logic       mem_rd;
  logic       mem_wr;
  wire  [7:0] mem_data;

  int checks = 0;
  int errors = 0;

  mem_arbiter_if #(.ADDR_W(5), .DATA_W(8)) p0_if ();
  mem_arbiter_if #(.ADDR_W(5), .DATA_W(8)) p1_if ();

  mem_arbiter #(.ADDR_W(5), .DATA_W(8)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .p0       (p0_if),
    .p1       (p1_if),
    .rdata    (rdata),
    .mem_addr (mem_addr),
    .mem_rd   (mem_rd),
    .mem_wr   (mem_wr),
    .mem_data (mem_data)
  );

  // Behavioural memory: drives the bus while rd is high, writes on the edge.
  logic [7:0] mem_array [32];
  assign mem_data = mem_rd ? mem_array[mem_addr] : 'z;
  always @(posedge clk) begin
    if (mem_wr) mem_array[mem_addr] <= mem_data;
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_p0(input logic req, input logic we, input logic [4:0] addr, input logic [7:0] wd);
    p0_if.req = req; p0_if.we = we; p0_if.addr = addr; p0_if.wdata = wd;
  endtask

  task automatic set_p1(input logic req, input logic we, input logic [4:0] addr, input logic [7:0] wd);
    p1_if.req = req; p1_if.we = we; p1_if.addr = addr; p1_if.wdata = wd;
  endtask

  // Bus monitor: no controller drive during reads, no rd/wr overlap, and
  // never a read cycle directly followed by a write cycle.
  logic prev_rd = 1'b0;
  always @(negedge clk) begin
    check("mon_oe_during_rd", {31'd0, dut.data_oe & mem_rd}, 32'd0);
    check("mon_rd_wr_overlap", {31'd0, mem_rd & mem_wr}, 32'd0);
    check("mon_turnaround", {31'd0, prev_rd & mem_wr}, 32'd0);
    prev_rd <= mem_rd;
  end

  initial begin
    #200000;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bit got;
    for (int i = 0; i < 32; i++) mem_array[i] = 8'h00;

    // Reset held 3 cycles with both requests high.
    rst_n = 1'b0;
    set_p0(1'b1, 1'b1, 5'd3, 8'h33);
    set_p1(1'b1, 1'b0, 5'd4, 8'h44);
    for (int i = 0; i < 3; i++) begin
      tick();
      check("rst_p0_gnt", {31'd0, p0_if.gnt}, 32'd0);
      check("rst_p1_gnt", {31'd0, p1_if.gnt}, 32'd0);
      check("rst_rd_wr", {30'd0, mem_rd, mem_wr}, 32'd0);
      check("rst_oe", {31'd0, dut.data_oe}, 32'd0);
      check("rst_addr", {27'd0, mem_addr}, 32'd0);
      check("rst_rdata", {24'd0, rdata}, 32'd0);
    end
    set_p0(1'b0, 1'b0, 5'd0, 8'h00);
    set_p1(1'b0, 1'b0, 5'd0, 8'h00);
    rst_n = 1'b1;
    tick();

    // Port-0 write 8'hAA to addr 0.
    set_p0(1'b1, 1'b1, 5'd0, 8'hAA);
    tick();
    check("wr_gnt", {31'd0, p0_if.gnt}, 32'd1);
    check("wr_strobe", {30'd0, mem_rd, mem_wr}, 32'd1);
    check("wr_bus", {24'd0, mem_data}, 32'hAA);
    check("wr_addr", {27'd0, mem_addr}, 32'd0);
    set_p0(1'b0, 1'b0, 5'd0, 8'h00);
    tick();
    check("wr_ack", {30'd0, p1_if.ack, p0_if.ack}, 32'd1);
    check("wr_one_cycle", {31'd0, mem_wr}, 32'd0);

    // Port-0 read of addr 0.
    set_p0(1'b1, 1'b0, 5'd0, 8'h00);
    tick();
    check("rd_gnt", {31'd0, p0_if.gnt}, 32'd1);
    check("rd_strobe", {30'd0, mem_rd, mem_wr}, 32'd2);
    set_p0(1'b0, 1'b0, 5'd0, 8'h00);
    tick();
    check("rd_capture_noack", {31'd0, p0_if.ack}, 32'd0);
    check("rd_capture_rd", {31'd0, mem_rd}, 32'd1);
    tick();
    check("rd_ack", {31'd0, p0_if.ack}, 32'd1);
    check("rd_data", {24'd0, rdata}, 32'hAA);

    // Simultaneous requests right after reset.
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    set_p0(1'b1, 1'b1, 5'd15, 8'hF0);
    set_p1(1'b1, 1'b0, 5'd15, 8'h00);
    tick();
    check("sim_first_gnt", {30'd0, p1_if.gnt, p0_if.gnt}, 32'd1);
    set_p0(1'b0, 1'b0, 5'd0, 8'h00);
    tick();
    check("sim_p0_ack", {31'd0, p0_if.ack}, 32'd1);
    tick();
    check("sim_second_gnt", {30'd0, p1_if.gnt, p0_if.gnt}, 32'd2);
    set_p1(1'b0, 1'b0, 5'd0, 8'h00);
    tick();
    tick();
    check("sim_p1_ack", {30'd0, p1_if.ack, p0_if.ack}, 32'd2);
    check("sim_p1_rdata", {24'd0, rdata}, 32'hF0);

    // Fairness: both requests held for 8 grants; port 1 was served last.
    set_p0(1'b1, 1'b1, 5'd1, 8'h11);
    set_p1(1'b1, 1'b1, 5'd2, 8'h22);
    for (int k = 0; k < 8; k++) begin
      got = 1'b0;
      for (int i = 0; i < 8 && !got; i++) begin
        tick();
        if (p0_if.gnt || p1_if.gnt) got = 1'b1;
      end
      check("fair_timeout", {31'd0, got}, 32'd1);
      check("fair_order", {30'd0, p1_if.gnt, p0_if.gnt}, (k % 2 == 0) ? 32'd1 : 32'd2);
      if (k == 7) begin
        set_p0(1'b0, 1'b0, 5'd0, 8'h00);
        set_p1(1'b0, 1'b0, 5'd0, 8'h00);
      end
    end
    tick();
    tick();

    // Abort: reset during CAPTURE of a port-0 read of addr 15.
    set_p0(1'b1, 1'b0, 5'd15, 8'h00);
    tick();
    check("abort_gnt", {31'd0, p0_if.gnt}, 32'd1);
    set_p0(1'b0, 1'b0, 5'd0, 8'h00);
    tick();
    check("abort_in_capture", {30'd0, dut.state}, {30'd0, ST_CAPTURE});
    rst_n = 1'b0;
    tick();
    check("abort_noack", {30'd0, p1_if.ack, p0_if.ack}, 32'd0);
    check("abort_idle", {30'd0, dut.state}, {30'd0, ST_IDLE});
    check("abort_strobes", {30'd0, mem_rd, mem_wr}, 32'd0);
    check("abort_rdata", {24'd0, rdata}, 32'd0);
    rst_n = 1'b1;
    tick();
    check("abort_still_noack", {31'd0, p0_if.ack}, 32'd0);
    set_p0(1'b1, 1'b0, 5'd15, 8'h00);
    tick();
    set_p0(1'b0, 1'b0, 5'd0, 8'h00);
    tick();
    tick();
    check("abort_reread_ack", {31'd0, p0_if.ack}, 32'd1);
    check("abort_reread_data", {24'd0, rdata}, 32'hF0);

    // Turnaround: port-1 read of 31 immediately followed by port-0 write to 31.
    set_p1(1'b1, 1'b0, 5'd31, 8'h00);
    tick();
    check("ta_rd_gnt", {30'd0, p1_if.gnt, p0_if.gnt}, 32'd2);
    set_p1(1'b0, 1'b0, 5'd0, 8'h00);
    set_p0(1'b1, 1'b1, 5'd31, 8'h5A);
    tick();
    check("ta_capture", {31'd0, mem_rd}, 32'd1);
    tick();
    check("ta_rd_ack", {31'd0, p1_if.ack}, 32'd1);
    check("ta_rd_data", {24'd0, rdata}, 32'h00);
    check("ta_idle_gap", {30'd0, mem_rd, mem_wr}, 32'd0);
    tick();
    check("ta_wr_gnt", {31'd0, p0_if.gnt}, 32'd1);
    check("ta_wr_strobe", {31'd0, mem_wr}, 32'd1);
    set_p0(1'b0, 1'b0, 5'd0, 8'h00);
    tick();
    check("ta_wr_ack", {31'd0, p0_if.ack}, 32'd1);
    set_p1(1'b1, 1'b0, 5'd31, 8'h00);
    tick();
    set_p1(1'b0, 1'b0, 5'd0, 8'h00);
    tick();
    tick();
    check("ta_readback_ack", {31'd0, p1_if.ack}, 32'd1);
    check("ta_readback_data", {24'd0, rdata}, 32'h5A);
    tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
